// File: rtl/neuron_pkg.sv
// Shared types and helpers for the perceptron sequencer.
//   state_t     : sequencer FSM states
//   DATA_W_DEF  : default weight/input width
//   ACC_W_DEF   : default accumulator width
//   idx_w()     : index width for a given term count (never below 1 bit)
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Signed multiply-accumulate unit.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears accumulator)
//   clr      : clear accumulator (priority over en)
//   en       : add a*b into the accumulator on this edge
//   a, b     : signed DATA_W operands
//   acc_sum  : accumulator value as it will be after this edge, i.e. the
//              stored total plus the term being added this cycle. Lets the
//              caller capture the final sum on the same edge the last term
//              lands.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_sum
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;

  always_comb begin
    acc_sum = acc;
    if (clr)
      acc_sum = '0;
    else if (en)
      acc_sum = acc + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else
      acc <= acc_sum;
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Runs one perceptron evaluation: walks weight ROM and input buffer in
// lockstep, accumulates weight*input over N_INPUTS terms, compares against
// the latched threshold and reports sum plus fire bit.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request evaluation (sampled in IDLE only)
//   threshold  : signed firing threshold, latched with start
//   busy       : evaluation in progress (RUN and DRAIN)
//   done       : one-cycle pulse, result/fire updated
//   rom_addr   : weight ROM address (ROM_BASE + index)
//   rom_dout   : weight ROM data, 1-cycle read latency
//   x_addr     : input buffer index
//   x_data     : input buffer data, 1-cycle read latency
//   result     : signed weighted sum, held until next done
//   fire       : result >= threshold, held with result
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing addresses for index 0..N_INPUTS-1
// DRAIN | last read returning, final term accumulated
// DONE  | done pulse, result/fire presented
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 10,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int ROM_BASE = 1,
  localparam int IDX_W   = idx_w(N_INPUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] threshold,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [IDX_W-1:0]  x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic [ACC_W-1:0]  result,
  output logic              fire
);

  if (N_INPUTS < 1) begin : g_n_chk
    $error("neuron_sequencer: N_INPUTS must be at least 1");
  end
  if (ACC_W < 2*DATA_W + $clog2(N_INPUTS)) begin : g_acc_chk
    $error("neuron_sequencer: ACC_W too narrow for worst-case sum");
  end
  if (ROM_BASE + N_INPUTS - 1 > 65535) begin : g_rom_chk
    $error("neuron_sequencer: ROM address range exceeds 16 bits");
  end

  localparam logic [15:0]      BASE16 = 16'(ROM_BASE);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_INPUTS - 1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic                     vld;
  logic signed [DATA_W-1:0] thr_q;
  logic signed [ACC_W-1:0]  thr_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     mac_clr;

  // Addresses derive from the index register, so they hold through DRAIN.
  assign rom_addr = BASE16 + 16'(idx);
  assign x_addr   = idx;
  assign thr_ext  = {{(ACC_W-DATA_W){thr_q[DATA_W-1]}}, thr_q};
  assign mac_clr  = (state == IDLE) && start;

  neuron_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (vld),
    .a       ($signed(rom_dout)),
    .b       ($signed(x_data)),
    .acc_sum (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      fire   <= 1'b0;
      idx    <= '0;
      vld    <= 1'b0;
      thr_q  <= '0;
    end else begin
      done <= 1'b0;
      // Read data for an address issued in RUN arrives one cycle later.
      vld  <= (state == RUN);
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= '0;
            thr_q <= $signed(threshold);
          end
        end
        RUN: begin
          if (idx == LAST)
            state <= DRAIN;
          else
            idx <= idx + IDX_W'(1);
        end
        DRAIN: begin
          // acc_sum already includes the final term landing on this edge.
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= acc_sum;
          fire   <= (acc_sum >= thr_ext);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer: directed cases plus random evaluations,
// checked against a plain-arithmetic dot-product model.
module tb_neuron_sequencer;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int RB = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [DW-1:0]        threshold;
  logic                 busy;
  logic                 done;
  logic [15:0]          rom_addr;
  logic [DW-1:0]        rom_dout;
  logic [3:0]           x_addr;
  logic [DW-1:0]        x_data;
  logic [AW-1:0]        result;
  logic                 fire;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] rom_mem [0:15];
  logic [DW-1:0] x_mem   [0:N-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_dout <= rom_mem[rom_addr[3:0]];
    x_data   <= x_mem[x_addr];
  end

  neuron_sequencer #(
    .N_INPUTS (N),
    .DATA_W   (DW),
    .ACC_W    (AW),
    .ROM_BASE (RB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .threshold (threshold),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .x_addr    (x_addr),
    .x_data    (x_data),
    .result    (result),
    .fire      (fire)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ref_sum();
    longint s = 0;
    for (int k = 0; k < N; k++)
      s += longint'($signed(rom_mem[RB+k])) * longint'($signed(x_mem[k]));
    return s;
  endfunction

  function automatic longint res_s();
    return longint'($signed(result));
  endfunction

  task automatic load(input int w [N], input int x [N]);
    for (int k = 0; k < 16; k++) rom_mem[k] = '0;
    for (int k = 0; k < N; k++) begin
      rom_mem[RB+k] = DW'(w[k]);
      x_mem[k]      = DW'(x[k]);
    end
  endtask

  // One evaluation; start sampled in cycle 0, checks addresses, latency,
  // sum and fire bit. Threshold is scrambled after acceptance.
  task automatic run_eval(input logic signed [DW-1:0] thr);
    longint exp_s;
    int     addr_err;
    bit     seen;
    exp_s     = ref_sum();
    start     = 1'b1;
    threshold = thr;
    addr_err  = 0;
    seen      = 1'b0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      tick();
      start     = 1'b0;
      threshold = DW'($urandom);
      if (c <= N && rom_addr != 16'(RB + c - 1)) addr_err++;
      if (c <= N && x_addr != 4'(c - 1)) addr_err++;
      if (c == 1) check("busy_run", busy, 1);
      if (c == N + 1) check("busy_drain", busy, 1);
      if (done) begin
        seen = 1'b1;
        check("done_cycle", c, N + 2);
        check("result", res_s(), exp_s);
        check("fire", fire, (exp_s >= longint'(thr)) ? 1 : 0);
        check("busy_done", busy, 0);
      end
    end
    check("done_seen", seen, 1);
    check("addr_seq", addr_err, 0);
    tick();
    check("done_pulse", done, 0);
    check("result_hold", res_s(), exp_s);
  endtask

  int w_a [N] = '{1, 3, 4, 5, 6, 8, 0, 0, 0, 0};
  int x_a [N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
  int x_m2[N] = '{-2, -2, -2, -2, -2, -2, -2, -2, -2, -2};
  int mn  [N] = '{-32768, -32768, -32768, -32768, -32768,
                  -32768, -32768, -32768, -32768, -32768};

  initial begin
    int done_cyc[$];
    int ndone;
    int busy_err;
    longint held;
    int wr[N];
    int xr[N];

    rst       = 1'b1;
    start     = 1'b0;
    threshold = '0;
    load(w_a, x_a);
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", res_s(), 0);
    check("rst_fire", fire, 0);
    check("rst_rom_addr", rom_addr, RB);
    check("rst_x_addr", x_addr, 0);
    rst = 1'b0;
    tick();

    run_eval(16'sd100);
    run_eval(16'sd118);
    run_eval(16'sd117);
    load(w_a, x_m2);
    run_eval(-16'sd60);
    run_eval(-16'sd50);
    load(mn, mn);
    run_eval(16'sd0);
    check("big_sum", res_s(), 64'sd10737418240);

    // Start pulses during RUN and DONE must be ignored.
    load(w_a, x_a);
    start = 1'b1; threshold = 16'sd100;
    ndone = 0; busy_err = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      start = (c == 5 || c == 12);
      if (done) ndone++;
      if (c >= 13 && busy) busy_err++;
    end
    start = 1'b0;
    check("ignored_starts_done", ndone, 1);
    check("ignored_starts_busy", busy_err, 0);
    check("ignored_starts_res", res_s(), 117);

    // Start held high: back-to-back evaluations every N+3 cycles.
    start = 1'b1; threshold = 16'sd100;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (done) done_cyc.push_back(c);
    end
    start = 1'b0;
    tick(); tick(); tick();
    check("cont_count", done_cyc.size(), 4);
    if (done_cyc.size() > 0) check("cont_first", done_cyc[0], N + 2);
    for (int i = 1; i < done_cyc.size(); i++)
      check("cont_gap", done_cyc[i] - done_cyc[i-1], N + 3);

    // Reset in cycle 6 of a run abandons it without a done pulse.
    load(w_a, x_m2);
    held = res_s();
    check("pre_rst_nonzero", (held != 0) ? 1 : 0, 1);
    start = 1'b1; threshold = 16'sd0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", res_s(), 0);
    check("midrst_addr", rom_addr, RB);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_eval(-16'sd60);

    // Random evaluations.
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < N; k++) begin
        wr[k] = int'($signed(DW'($urandom)));
        xr[k] = int'($signed(DW'($urandom)));
      end
      if (t % 4 == 0) begin
        for (int k = 0; k < N; k++) xr[k] = $urandom_range(0, 20) - 10;
        for (int k = 0; k < N; k++) wr[k] = $urandom_range(0, 20) - 10;
      end
      load(wr, xr);
      run_eval(DW'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
Controller that runs one perceptron evaluation.
- Walks the neuron weight ROM and the input-vector buffer in lockstep. Both are read-only stores with registered 1-cycle-latency read data.
- Multiply-accumulates weight × input over N_INPUTS terms, compares the sum against a threshold and reports sum plus fire bit.
- Sits between the layer scheduler (start/done) and one weight ROM plus its input buffer.

Parameters:
- N_INPUTS, 10, number of weight/input pairs per evaluation (≥1).
- DATA_W, 16, width of weights and inputs; two's-complement signed.
- ACC_W, 40, accumulator width; must be ≥ 2*DATA_W + clog2(N_INPUTS).
- ROM_BASE, 1, ROM address of weight 0. Weight k is at ROM_BASE+k.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an evaluation; sampled only in IDLE.
- threshold  in  DATA_W  signed firing threshold; sign-extended to ACC_W; sampled with start.
- busy  out  1  high from cycle after accepted start through DRAIN.
- done  out  1  one-cycle pulse when result/fire are updated.
- rom_addr  out  16  weight ROM address.
- rom_dout  in  DATA_W  weight ROM read data; valid 1 cycle after rom_addr.
- x_addr  out  clog2(N_INPUTS)  input buffer index k.
- x_data  in  DATA_W  input buffer read data; valid 1 cycle after x_addr.
- result  out  ACC_W  signed weighted sum; held until next done.
- fire  out  1  result ≥ threshold (signed); held with result.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, result=0, fire=0, rom_addr=ROM_BASE, x_addr=0, accumulator=0, index=0.
- Reset mid-operation: abandon the evaluation and return to IDLE with the reset values above on the next edge. No done pulse.
- State IDLE:
  - start=1 → RUN next cycle; clear accumulator and index; latch threshold.
  - start=0 → stay in IDLE.
- State RUN:
  - rom_addr = ROM_BASE + index; x_addr = index.
  - index increments each cycle.
  - At index = N_INPUTS-1 → DRAIN next cycle.
  - RUN lasts exactly N_INPUTS cycles.
- Accumulate pipeline:
  - A valid-delay flag marks each cycle whose addresses were issued in RUN.
  - On the following edge: acc ← acc + sext(rom_dout × x_data). The product is signed, 2*DATA_W bits.
  - Data for the last issued index is accumulated at the end of DRAIN.
- State DRAIN: one cycle, no new address issued (addresses hold their last value), then → DONE.
- State DONE: one cycle.
  - done=1; result = acc; fire = (acc ≥ sext(threshold)).
  - Then → IDLE.
- Latency: start sampled high at cycle s → done high in cycle s+N_INPUTS+2 (N=10, start at 0 → done at 12). Next start is accepted in cycle s+N_INPUTS+3.
- start while busy or in DONE: ignored; no queuing.
- threshold changes after acceptance: no effect on the current evaluation.
- Overflow: none possible given the ACC_W constraint; no saturation logic. An elaboration-time assertion checks ACC_W.
- rom_addr is a 16-bit wrap-around add; ROM_BASE+N_INPUTS-1 must be ≤ 16'hFFFF (elaboration check).

Decomposition:
- Package neuron_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - DATA_W/ACC_W default constants;
  - a clog2-based index-width helper.
- Sub-module neuron_mac:
  - inputs: clk, rst, clr, en, DATA_W operands a/b;
  - output: ACC_W accumulator;
  - behaviour: signed multiply plus accumulate, clr has priority over en.
- The FSM, counter and compare stay in neuron_sequencer.

Test Plan:
- ROM words 1..10 = {1,3,4,5,6,8,0,0,0,0}, x = {1..10}, threshold=100, start at cycle 0 → rom_addr 1..10 on cycles 1..10; done at cycle 12; result=117; fire=1.
- Same data, threshold=118 → result=117, fire=0. Threshold=117 → fire=1 (equality fires).
- All x = -2 with the same weights → result=-54. Threshold=-60 → fire=1; threshold=-50 → fire=0.
- All weights and inputs = 16'h8000 (-32768) → result = 10 × 2^30 = 10737418240 with no wrap; fire=1 for threshold=0.
- start held high continuously → evaluations complete every 13 cycles. start pulses during busy and DONE are ignored; result holds between done pulses.
- rst asserted at cycle 6 of a run → cycle 7: state IDLE, busy=0, result=0, no done. A fresh start then produces the correct sum.
